// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, h/v counters,
// registered sync/active decodes and line/frame strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CLK_DIV  = 1,
    parameter int COORD_W  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               pixel_tick,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_LO    = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_HI    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_LO    = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_HI    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (((COORD_W < 31) && ((1 << COORD_W) < MAX_TOTAL)) || (CLK_DIV < 1) ||
        (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic               pixel_tick_q, pixel_tick_d, line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               advance, h_wrap, v_wrap;

    // Decodes use the next counter values so the registered syncs line up with the registered counts.
    always_comb begin
        advance       = en && (div_q == DIV_LAST);
        h_wrap        = (hcount_q == H_LAST);
        v_wrap        = (vcount_q == V_LAST);
        div_d         = div_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        if (en) begin
            div_d = advance ? '0 : div_q + 1'b1;
        end
        if (advance) begin
            hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            end
        end
        hsync_d       = ((hcount_d >= HS_LO) && (hcount_d <= HS_HI)) ? HS_POL : ~HS_POL;
        vsync_d       = ((vcount_d >= VS_LO) && (vcount_d <= VS_HI)) ? VS_POL : ~VS_POL;
        active_d      = (hcount_d < H_ACT) && (vcount_d < V_ACT);
        pixel_tick_d  = advance;
        line_start_d  = advance && h_wrap;
        frame_start_d = advance && h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            pixel_tick_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pixel_tick_q  <= pixel_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign pixel_tick  = pixel_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 1056×628 coordinate counter with configurable horizontal and vertical timing and sync polarities. It adds a pixel-clock divider, a run enable, registered sync/active decodes and line/frame strobes. It sits at the head of the video pipeline and drives the pixel renderer (`hcount`/`vcount`/`active`) and the VGA connector (`hsync`/`vsync`).

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, hsync asserted level
- `VS_POL`, 1, vsync asserted level
- `CLK_DIV`, 1, clk cycles per pixel (≥1)
- `COORD_W`, 11, counter width

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low freezes all state
- `hcount`  out  COORD_W  horizontal position, 0..H_TOTAL-1
- `vcount`  out  COORD_W  vertical position, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, level per HS_POL
- `vsync`  out  1  vertical sync, level per VS_POL
- `active`  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
- `pixel_tick`  out  1  one-cycle pulse on each counter advance
- `line_start`  out  1  one-cycle pulse when hcount wraps to 0
- `frame_start`  out  1  one-cycle pulse when both counters wrap to (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. The defaults give 1056/628.
- Elaboration error if 2^COORD_W < max(H_TOTAL,V_TOTAL), if CLK_DIV<1, or if any timing parameter is 0.
- Divider:
  - `div` counts 0..CLK_DIV-1 on cycles with en=1.
  - The advance condition is en=1 and div==CLK_DIV-1. At that point div returns to 0.
  - With CLK_DIV=1, every enabled cycle advances.
- Advance:
  - hcount+1, or wrap to 0 at H_TOTAL-1.
  - On an hcount wrap: vcount+1, or wrap to 0 at V_TOTAL-1.
- Sync windows:
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1, else ~VS_POL.
  - vsync edges coincide with hcount=0.
- All outputs are registers. hsync, vsync and active are decoded from the next counter values, so they always match the hcount/vcount presented in the same cycle. Combinational output paths are not permitted.
- en=0:
  - counters, div, hsync, vsync and active hold.
  - pixel_tick, line_start and frame_start are 0.
- Strobes:
  - pixel_tick is 1 in the cycle following each advance edge.
  - line_start is 1 only when that advance wrapped hcount.
  - frame_start is 1 only when it wrapped both counters; line_start is also 1 in that cycle.

## Timing
- Reset values:
  - hcount=0, vcount=0, div=0, active=1
  - hsync=~HS_POL, vsync=~VS_POL
  - pixel_tick=0, line_start=0, frame_start=0
- Reset wins over en. It takes effect at the next edge from any state, mid-line or mid-frame.
- Reset does not produce line_start or frame_start.
- Latency: a counter advance is visible one edge after the qualifying cycle. Strobes and decodes are visible at the same edge.
- First advance after reset release with en held high: CLK_DIV edges after the first edge at which rst=0.
- Simultaneous hcount and vcount wrap: both counters go to 0 at the same edge, with line_start=frame_start=1.
- Lowering en mid-divide keeps the div value. The divide resumes from that value when en returns high.

## Test plan
- **Reset and line wrap.** Defaults, CLK_DIV=1, en=1, rst for 2 cycles then release.
  - Before the first edge after release: all outputs at reset values.
  - 1055 edges later: hcount=1055.
  - Next edge: hcount=0, vcount=1, line_start=1 for 1 cycle, frame_start=0.
- **Horizontal decode on line 0.** hsync=1 exactly for hcount 840..967. active=1 for hcount 0..799 and 0 at hcount=800.
- **Frame wrap.** Run 663168 pixel advances.
  - vsync=1 exactly for vcount 601..604.
  - Final advance: (1055,627)→(0,0) with frame_start=1 and line_start=1 together.
- **Divider and polarity.** CLK_DIV=4, HS_POL=0, VS_POL=0.
  - hcount increments every 4 clk cycles, and pixel_tick pulses once per 4 cycles.
  - hsync=0 inside the window and 1 outside it.
- **Enable hold.** Drop en for 10 cycles at hcount=500 with div=2 (CLK_DIV=4).
  - All outputs hold and strobes stay 0.
  - After en returns high, the next advance occurs 2 enabled cycles later.
- **Mid-frame reset.** Assert rst at (1000,300), with en held high through the reset.
  - Next edge: hcount=0, vcount=0, hsync/vsync inactive, no strobes.
  - Counting restarts normally after release.
